// File: rtl/avalon_clint_if.sv
// Avalon-MM slave bus bundle for the core-local interruptor register window.
interface avalon_clint_if;
  logic        avn_read;
  logic        avn_write;
  logic [15:0] avn_address;
  logic [3:0]  avn_byte_enable;
  logic [31:0] avn_writedata;
  logic [31:0] avn_readdata;
  logic        avn_waitrequest;

  modport master (
    output avn_read, avn_write, avn_address, avn_byte_enable, avn_writedata,
    input  avn_readdata, avn_waitrequest
  );

  modport slave (
    input  avn_read, avn_write, avn_address, avn_byte_enable, avn_writedata,
    output avn_readdata, avn_waitrequest
  );
endinterface

// File: rtl/avalon_clint.sv
// Core-local interruptor: prescaled 64-bit mtime, 64-bit mtimecmp and msip,
// exposed as 32-bit Avalon-MM registers; drives software/timer interrupts.
module avalon_clint #(
  parameter int unsigned TICK_DIV = 50
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          halt,
  avalon_clint_if.slave avn,
  output logic          software_interrupt,
  output logic          timer_interrupt
);

  localparam logic [15:0] TICK_MAX   = 16'(TICK_DIV - 1);
  localparam logic [13:0] A_MSIP     = 14'h0000;
  localparam logic [13:0] A_CMP_LO   = 14'h1000;
  localparam logic [13:0] A_CMP_HI   = 14'h1001;
  localparam logic [13:0] A_MTIME_LO = 14'h2FFE;
  localparam logic [13:0] A_MTIME_HI = 14'h2FFF;

  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        timer_irq_q, timer_irq_d;
  logic [31:0] rdata_q, rdata_d;
  logic        tick;
  logic [13:0] word;
  logic        unused_addr_lsbs;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) res[8*k +: 8] = wdata[8*k +: 8];
    end
    return res;
  endfunction

  assign word             = avn.avn_address[15:2];
  assign unused_addr_lsbs = ^avn.avn_address[1:0];
  assign tick             = !halt && (tick_cnt_q == TICK_MAX);

  // NOTE: every variable gets a default before any conditional update so the
  // block stays purely combinational and no latch is inferred.
  always_comb begin
    tick_cnt_d  = tick_cnt_q;
    mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d  = mtimecmp_q;
    msip_d      = msip_q;
    rdata_d     = rdata_q;
    timer_irq_d = (mtime_q >= mtimecmp_q);

    if (!halt) tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;

    // A software write to mtime overrides the tick; the other word keeps its
    // pre-increment value so no carry leaks across.
    if (avn.avn_write) begin
      unique case (word)
        A_MSIP:     if (avn.avn_byte_enable[0]) msip_d = avn.avn_writedata[0];
        A_CMP_LO:   mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], avn.avn_writedata, avn.avn_byte_enable);
        A_CMP_HI:   mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], avn.avn_writedata, avn.avn_byte_enable);
        A_MTIME_LO: mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], avn.avn_writedata, avn.avn_byte_enable)};
        A_MTIME_HI: mtime_d = {merge_bytes(mtime_q[63:32], avn.avn_writedata, avn.avn_byte_enable), mtime_q[31:0]};
        default: ;
      endcase
    end

    if (avn.avn_read) begin
      unique case (word)
        A_MSIP:     rdata_d = {31'd0, msip_q};
        A_CMP_LO:   rdata_d = mtimecmp_q[31:0];
        A_CMP_HI:   rdata_d = mtimecmp_q[63:32];
        A_MTIME_LO: rdata_d = mtime_q[31:0];
        A_MTIME_HI: rdata_d = mtime_q[63:32];
        default:    rdata_d = 32'd0;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_q  <= 16'd0;
      mtime_q     <= 64'd0;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q      <= 1'b0;
      timer_irq_q <= 1'b0;
      rdata_q     <= 32'd0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      timer_irq_q <= timer_irq_d;
      rdata_q     <= rdata_d;
    end
  end

  assign avn.avn_readdata    = rdata_q;
  assign avn.avn_waitrequest = 1'b0;
  assign software_interrupt  = msip_q;
  assign timer_interrupt     = timer_irq_q;

endmodule

// File: tb/tb_avalon_clint.sv
// Directed bench for avalon_clint with TICK_DIV=4; inputs change and outputs
// are sampled 1 time unit after the rising edge.
module tb_avalon_clint;
  logic clk = 1'b0;
  logic rst_n;
  logic halt;
  logic sw_irq, tm_irq;
  int   vectors = 0;
  int   fails   = 0;

  avalon_clint_if bus();

  avalon_clint #(.TICK_DIV(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .halt               (halt),
    .avn                (bus.slave),
    .software_interrupt (sw_irq),
    .timer_interrupt    (tm_irq)
  );

  always #5 clk = ~clk;

  task automatic bus_cycle(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [31:0] data, input logic [3:0] be);
    bus.avn_read        = rd;
    bus.avn_write       = wr;
    bus.avn_address     = addr;
    bus.avn_writedata   = data;
    bus.avn_byte_enable = be;
    @(posedge clk); #1;
    bus.avn_read  = 1'b0;
    bus.avn_write = 1'b0;
  endtask

  task automatic wr_reg(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] be);
    bus_cycle(1'b0, 1'b1, addr, data, be);
  endtask

  task automatic rd_reg(input logic [15:0] addr);
    bus_cycle(1'b1, 1'b0, addr, 32'd0, 4'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Exactly TICK_DIV unhalted edges always contain exactly one increment.
  task automatic run_one_tick();
    halt = 1'b0;
    repeat (4) @(posedge clk);
    #1 halt = 1'b1;
  endtask

  task automatic expect_rd(input logic [15:0] addr, input logic [31:0] exp, input string name);
    rd_reg(addr);
    vectors++;
    if (bus.avn_readdata !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, bus.avn_readdata, exp);
    end
  endtask

  task automatic test_reset();
    halt = 1'b1;
    do_reset();
    vectors++;
    if (bus.avn_readdata !== 32'd0 || bus.avn_waitrequest !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got rdata=%h wait=%b expected 0/0", bus.avn_readdata, bus.avn_waitrequest);
    end
    expect_rd(16'h4000, 32'hFFFF_FFFF, "reset_cmp_lo");
    expect_rd(16'h4004, 32'hFFFF_FFFF, "reset_cmp_hi");
    expect_rd(16'hBFF8, 32'd0,         "reset_mtime_lo");
    expect_rd(16'h0000, 32'd0,         "reset_msip");
    vectors++;
    if (sw_irq !== 1'b0 || tm_irq !== 1'b0) begin
      fails++;
      $display("FAIL reset_irqs: got sw=%b tm=%b expected 0/0", sw_irq, tm_irq);
    end
  endtask

  task automatic test_reset_write();
    halt = 1'b1;
    rst_n = 1'b0;
    wr_reg(16'h0000, 32'h1, 4'b0001);
    rst_n = 1'b1;
    vectors++;
    if (sw_irq !== 1'b0) begin
      fails++;
      $display("FAIL reset_discards_write: got sw=%b expected 0", sw_irq);
    end
  endtask

  task automatic test_timer();
    halt = 1'b0;
    do_reset();
    wr_reg(16'h4000, 32'd3, 4'hF);
    wr_reg(16'h4004, 32'd0, 4'hF);
    repeat (10) @(posedge clk);
    #1;
    vectors++;
    if (tm_irq !== 1'b0) begin
      fails++;
      $display("FAIL timer_before_match: got %b expected 0", tm_irq);
    end
    expect_rd(16'hBFF8, 32'd3, "timer_mtime_12cyc");
    vectors++;
    if (tm_irq !== 1'b1) begin
      fails++;
      $display("FAIL timer_fire: got %b expected 1", tm_irq);
    end
    wr_reg(16'h4000, 32'd100, 4'hF);
    vectors++;
    if (tm_irq !== 1'b1) begin
      fails++;
      $display("FAIL timer_clear_lag: got %b expected 1", tm_irq);
    end
    @(posedge clk); #1;
    vectors++;
    if (tm_irq !== 1'b0) begin
      fails++;
      $display("FAIL timer_clear: got %b expected 0", tm_irq);
    end
  endtask

  task automatic test_carry();
    halt = 1'b1;
    wr_reg(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
    wr_reg(16'hBFFC, 32'd0, 4'hF);
    run_one_tick();
    expect_rd(16'hBFF8, 32'd0, "carry_lo");
    expect_rd(16'hBFFC, 32'd1, "carry_hi");
    wr_reg(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
    wr_reg(16'hBFFC, 32'hFFFF_FFFF, 4'hF);
    run_one_tick();
    expect_rd(16'hBFF8, 32'd0, "wrap_lo");
    expect_rd(16'hBFFC, 32'd0, "wrap_hi");
  endtask

  task automatic test_msip();
    halt = 1'b1;
    wr_reg(16'h0000, 32'h1, 4'b0001);
    vectors++;
    if (sw_irq !== 1'b1) begin
      fails++;
      $display("FAIL msip_set: got %b expected 1", sw_irq);
    end
    wr_reg(16'h0000, 32'h0, 4'b0000);
    vectors++;
    if (sw_irq !== 1'b1) begin
      fails++;
      $display("FAIL msip_no_lane: got %b expected 1", sw_irq);
    end
    wr_reg(16'h0000, 32'hFFFF_FFFF, 4'b1111);
    expect_rd(16'h0000, 32'h1, "msip_upper_bits_zero");
    wr_reg(16'h0000, 32'h0, 4'b0001);
    vectors++;
    if (sw_irq !== 1'b0) begin
      fails++;
      $display("FAIL msip_clear: got %b expected 0", sw_irq);
    end
  endtask

  task automatic test_halt();
    halt = 1'b0;
    do_reset();
    repeat (2) @(posedge clk);
    #1 halt = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    expect_rd(16'hBFF8, 32'd0, "halt_frozen");
    halt = 1'b0;
    @(posedge clk); #1;
    expect_rd(16'hBFF8, 32'd0, "halt_resume_early");
    expect_rd(16'hBFF8, 32'd1, "halt_resume_tick");
    halt = 1'b1;
  endtask

  task automatic test_write_tick();
    halt = 1'b1;
    do_reset();
    wr_reg(16'hBFF8, 32'h1FF, 4'hF);
    halt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    wr_reg(16'hBFF8, 32'h55, 4'b0001);
    halt = 1'b1;
    expect_rd(16'hBFF8, 32'h155, "write_wins_lo");
    expect_rd(16'hBFFC, 32'h0,   "write_wins_hi");
    run_one_tick();
    expect_rd(16'hBFF8, 32'h156, "prescaler_kept");
  endtask

  task automatic test_back_to_back();
    halt = 1'b1;
    wr_reg(16'h4000, 32'h1111_1111, 4'hF);
    bus_cycle(1'b1, 1'b1, 16'h4000, 32'h2222_2222, 4'hF);
    vectors++;
    if (bus.avn_readdata !== 32'h1111_1111) begin
      fails++;
      $display("FAIL rw_same_cycle_old: got %h expected %h", bus.avn_readdata, 32'h1111_1111);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.avn_readdata !== 32'h1111_1111) begin
      fails++;
      $display("FAIL readdata_hold: got %h expected %h", bus.avn_readdata, 32'h1111_1111);
    end
    expect_rd(16'h4000, 32'h2222_2222, "rw_same_cycle_new");
    wr_reg(16'h4004, 32'hAABB_CCDD, 4'b0110);
    expect_rd(16'h4006, 32'hFFBB_CCFF, "cmp_hi_lanes_addr_lsbs");
    wr_reg(16'h1234, 32'hDEAD_BEEF, 4'hF);
    expect_rd(16'h1234, 32'd0, "unmapped_read");
  endtask

  initial begin
    rst_n               = 1'b1;
    halt                = 1'b1;
    bus.avn_read        = 1'b0;
    bus.avn_write       = 1'b0;
    bus.avn_address     = 16'd0;
    bus.avn_writedata   = 32'd0;
    bus.avn_byte_enable = 4'd0;
    @(posedge clk); #1;
    test_reset();
    test_reset_write();
    test_timer();
    test_carry();
    test_msip();
    test_halt();
    test_write_tick();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
